// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for the prescaled pulse generator.
//   pwm_count_t    - count type wide enough for the largest PRESCALER (2^16)
//   pwm_cnt_w()    - counter width for a given prescaler, max(1, $clog2(p))
//   pwm_params_ok()- legality check used at elaboration time
package pwm_pkg;

  typedef logic [16:0] pwm_count_t;

  localparam int PWM_PRESCALER_MAX = 65536;

  function automatic int pwm_cnt_w(input int p);
    int w;
    w = $clog2(p);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit pwm_params_ok(input int prescaler, input int pulse_width,
                                       input int offset);
    return (prescaler >= 1) && (prescaler <= PWM_PRESCALER_MAX) &&
           (pulse_width >= 0) && (pulse_width <= prescaler) &&
           (offset >= 0) && (offset < prescaler);
  endfunction

endpackage

// File: rtl/pwm_tick_counter.sv
// pwm_tick_counter: modulo-PRESCALER counter advanced by ena.
// Optional feature macro: PWM_GEN_SYNC_CLR_EN adds a synchronous clear input.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset (cnt <= 0)
//   ena   in   advance enable
//   clr   in   synchronous clear, priority over ena (only with PWM_GEN_SYNC_CLR_EN)
//   cnt   out  current count, 0..PRESCALER-1
module pwm_tick_counter
  import pwm_pkg::*;
#(
  parameter int PRESCALER = 5,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
`ifdef PWM_GEN_SYNC_CLR_EN
  input  logic             clr,
`endif
  output logic [CNT_W-1:0] cnt
);

  // Terminal value computed in the full-size type, then narrowed; PRESCALER-1
  // always fits in CNT_W bits.
  localparam pwm_count_t       LAST_FULL = pwm_count_t'(PRESCALER - 1);
  localparam logic [CNT_W-1:0] LAST      = LAST_FULL[CNT_W-1:0];

  logic clr_int;

`ifdef PWM_GEN_SYNC_CLR_EN
  assign clr_int = clr;
`else
  assign clr_int = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr_int) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_pulse_generator.sv
// pwm_pulse_generator: enable-driven prescaled pulse generator. Counts ena ticks
// modulo PRESCALER and drives a registered pulse for PULSE_WIDTH ticks of each
// period, starting at tick OFFSET (window may wrap past PRESCALER-1).
// Instances cascade by feeding pulse_out into the next stage's ena.
// Optional feature macro: PWM_GEN_SYNC_CLR_EN adds input clr (sync clear).
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   ena        in   tick enable
//   clr        in   synchronous clear, priority over ena (only with PWM_GEN_SYNC_CLR_EN)
//   pulse_out  out  registered pulse/strobe
// Timing contract: ena is sampled at each rising edge; pulse_out after that edge
// reflects whether the sampled tick was in-window (1 cycle latency) and is 0
// after any edge where ena was 0. There is no back-pressure.
module pwm_pulse_generator
  import pwm_pkg::*;
#(
  parameter int PRESCALER   = 5,
  parameter int PULSE_WIDTH = 1,
  parameter int OFFSET      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
`ifdef PWM_GEN_SYNC_CLR_EN
  input  logic clr,
`endif
  output logic pulse_out
);

  localparam int CNT_W = pwm_cnt_w(PRESCALER);

  if (!pwm_params_ok(PRESCALER, PULSE_WIDTH, OFFSET)) begin : g_param_error
    $error("pwm_pulse_generator: illegal PRESCALER=%0d PULSE_WIDTH=%0d OFFSET=%0d",
           PRESCALER, PULSE_WIDTH, OFFSET);
  end

  // One extra bit so cnt + PRESCALER - OFFSET never overflows and PULSE_WIDTH
  // equal to 2^CNT_W is representable.
  localparam logic [CNT_W:0] P_EXT   = (CNT_W+1)'(PRESCALER);
  localparam logic [CNT_W:0] PW_EXT  = (CNT_W+1)'(PULSE_WIDTH);
  localparam logic [CNT_W:0] OFF_EXT = (CNT_W+1)'(OFFSET);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   rel;
  logic             in_win;
  logic             clr_int;

  pwm_tick_counter #(
    .PRESCALER (PRESCALER),
    .CNT_W     (CNT_W)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .ena (ena),
`ifdef PWM_GEN_SYNC_CLR_EN
    .clr (clr),
`endif
    .cnt (cnt)
  );

`ifdef PWM_GEN_SYNC_CLR_EN
  assign clr_int = clr;
`else
  assign clr_int = 1'b0;
`endif

  // rel = (cnt - OFFSET) mod PRESCALER; sum lies in 1..2*PRESCALER-1, so a
  // single conditional subtract completes the modulo.
  always_comb begin
    sum    = {1'b0, cnt} + P_EXT - OFF_EXT;
    rel    = (sum >= P_EXT) ? (sum - P_EXT) : sum;
    in_win = (rel < PW_EXT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_out <= 1'b0;
    end else if (clr_int) begin
      pulse_out <= 1'b0;
    end else if (ena) begin
      pulse_out <= in_win;
    end else begin
      pulse_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_pulse_generator.sv
module tb_pwm_pulse_generator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic ena1 = 1'b0;
  logic ena_cas = 1'b0;
  logic ena3 = 1'b0;
  logic ena4 = 1'b0;
  logic ena5 = 1'b0;

  logic p1, p_cas1, p_cas2, p3, p4, p5a, p5b, p6;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
`ifdef PWM_GEN_SYNC_CLR_EN
  `define CLR_CONN .clr(clr),
`else
  `define CLR_CONN
`endif

  pwm_pulse_generator #(.PRESCALER(5), .PULSE_WIDTH(1), .OFFSET(0)) u1 (
    .clk(clk), .rst(rst), .ena(ena1), `CLR_CONN .pulse_out(p1));
  pwm_pulse_generator #(.PRESCALER(5), .PULSE_WIDTH(1), .OFFSET(0)) u_cas1 (
    .clk(clk), .rst(rst), .ena(ena_cas), `CLR_CONN .pulse_out(p_cas1));
  pwm_pulse_generator #(.PRESCALER(5), .PULSE_WIDTH(1), .OFFSET(0)) u_cas2 (
    .clk(clk), .rst(rst), .ena(p_cas1), `CLR_CONN .pulse_out(p_cas2));
  pwm_pulse_generator #(.PRESCALER(8), .PULSE_WIDTH(3), .OFFSET(6)) u3 (
    .clk(clk), .rst(rst), .ena(ena3), `CLR_CONN .pulse_out(p3));
  pwm_pulse_generator #(.PRESCALER(4), .PULSE_WIDTH(2), .OFFSET(0)) u4 (
    .clk(clk), .rst(rst), .ena(ena4), `CLR_CONN .pulse_out(p4));
  pwm_pulse_generator #(.PRESCALER(4), .PULSE_WIDTH(0), .OFFSET(0)) u5a (
    .clk(clk), .rst(rst), .ena(ena5), `CLR_CONN .pulse_out(p5a));
  pwm_pulse_generator #(.PRESCALER(4), .PULSE_WIDTH(4), .OFFSET(0)) u5b (
    .clk(clk), .rst(rst), .ena(ena5), `CLR_CONN .pulse_out(p5b));
  pwm_pulse_generator #(.PRESCALER(1), .PULSE_WIDTH(1), .OFFSET(0)) u6 (
    .clk(clk), .rst(rst), .ena(ena5), `CLR_CONN .pulse_out(p6));

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] ena5_pat;
    logic        e;
    int          m;
    int          c;

    // Test 1 reset phase: ena1 high, reset held for 10 edges -> output stays 0.
    rst  = 1'b0;
    ena1 = 1'b1;
    #1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 0 || j == 9) begin
        check($sformatf("t1 in reset edge %0d", j), p1, 1'b0);
        check($sformatf("t2 in reset edge %0d", j), p_cas2, 1'b0);
      end
    end

    // Tests 1+2: release with ena1/ena_cas high. Stage 1 pulses after edges
    // 1,6,11,...; stage 2 after edges 2 and 27.
    rst     = 1'b1;
    ena_cas = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      tick();
      check($sformatf("t1 u1 edge %0d", j), p1, (j % 5) == 1);
      check($sformatf("t2 stage1 edge %0d", j), p_cas1, (j % 5) == 1);
      check($sformatf("t2 stage2 edge %0d", j), p_cas2, (j == 2) || (j == 27));
    end
    ena1    = 1'b0;
    ena_cas = 1'b0;
    tick();
    check("t1 idle after ena drop", p1, 1'b0);

    // Test 3: (8,3,6) wrap window, high when sampled cnt is 6,7,0.
    ena3 = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      tick();
      c = (j - 1) % 8;
      check($sformatf("t3 edge %0d cnt %0d", j, c), p3, (c == 0) || (c >= 6));
    end
    ena3 = 1'b0;

    // Test 4: (4,2,0) with ena toggling; enabled ticks sample cnt 0,1,2,3,...
    for (int j = 1; j <= 16; j++) begin
      e    = (j % 2) == 1;
      ena4 = e;
      tick();
      m = (j + 1) / 2;
      check($sformatf("t4 edge %0d", j), p4, e && (((m - 1) % 4) < 2));
    end
    ena4 = 1'b0;
    tick();
    // u4 has had 8 enabled ticks: cnt back at 0.

    // Test 5: reset mid-pulse drops pulse_out asynchronously.
    ena4 = 1'b1;
    tick();
    check("t5 pulse before reset", p4, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("t5 async drop", p4, 1'b0);
    tick();
    check("t5 held in reset", p4, 1'b0);
    tick();
    rst = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check($sformatf("t5 restart edge %0d", j), p4, ((j - 1) % 4) < 2);
    end
    ena4 = 1'b0;
    tick();

    // Test 5 edges: PW=0 stays low, PW=PRESCALER and PRESCALER=1 follow ena by 1.
    ena5_pat = 16'b1101_0011_1000_1011;
    for (int j = 0; j < 16; j++) begin
      e    = ena5_pat[j];
      ena5 = e;
      tick();
      check($sformatf("t5 pw0 edge %0d", j), p5a, 1'b0);
      check($sformatf("t5 pwfull edge %0d", j), p5b, e);
      check($sformatf("t5 presc1 edge %0d", j), p6, e);
    end
    ena5 = 1'b0;
    tick();

`ifdef PWM_GEN_SYNC_CLR_EN
    // Test 6: u1 restarted by the reset in test 5 (cnt=0). Advance to cnt=3,
    // then clear with ena high.
    ena1 = 1'b1;
    tick();
    check("t6 first pulse", p1, 1'b1);
    tick();
    tick();
    check("t6 cnt2 sampled", p1, 1'b0);
    clr = 1'b1;
    tick();
    check("t6 clr forces low", p1, 1'b0);
    clr = 1'b0;
    tick();
    check("t6 restart from cnt0", p1, 1'b1);
    tick();
    check("t6 cnt1 after clr", p1, 1'b0);
    ena1 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
